// File: rtl/mux2a1_ochobits_cond_pkg.sv
// Shared definitions for the two-lane to one-lane byte interleaver.
// Contents:
//   WIDTH_DEF, DEPTH_DEF  default word width and per-lane FIFO depth.
//   LANE0, LANE1          lane index values carried by `sel`.
package mux_pkg;

  localparam int WIDTH_DEF = 8;
  localparam int DEPTH_DEF = 2;

  localparam logic LANE0 = 1'b0;
  localparam logic LANE1 = 1'b1;

endpackage

// File: rtl/mux2a1_ochobits_cond_if.sv
// Bus bundle for mux2a1_ochobits_cond.
//
// Handshake: valid-only, there is no ready.
//   - validN=1 at a rising edge offers data_inN to lane N. If the lane is full
//     and not popped at that edge, the word is dropped and ovfN latches.
//   - valid_out=1 marks data_out as a new word for exactly that cycle, and the
//     downstream serialiser must take it.
//
// Modports:
//   master  traffic source: drives the lane inputs and observes the outputs.
//   slave   the interleaver: receives the lane inputs and drives the outputs.
interface mux2a1_ochobits_cond_if #(
  parameter int WIDTH = mux_pkg::WIDTH_DEF
);
  logic             valid0;
  logic [WIDTH-1:0] data_in0;
  logic             valid1;
  logic [WIDTH-1:0] data_in1;
  logic             valid_out;
  logic [WIDTH-1:0] data_out;
  logic             sel;
  logic             full0;
  logic             full1;
  logic             ovf0;
  logic             ovf1;

  modport master (
    output valid0, data_in0, valid1, data_in1,
    input  valid_out, data_out, sel, full0, full1, ovf0, ovf1
  );

  modport slave (
    input  valid0, data_in0, valid1, data_in1,
    output valid_out, data_out, sel, full0, full1, ovf0, ovf1
  );
endinterface

// File: rtl/mux2a1_ochobits_cond_lane_fifo.sv
// lane_fifo: one lane's elastic buffer.
// Ports:
//   clk, reset  rising-edge clock, synchronous active-high reset.
//   push, din   write request and word.
//   pop         remove the head word (ignored when empty).
//   head        current head word (meaningful only when not empty).
//   count       number of stored words, 0..DEPTH.
//   full        count == DEPTH.
//   empty       count == 0.
//   ovf         sticky: a push was dropped because the FIFO was full.
module lane_fifo
  import mux_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic [WIDTH-1:0]           din,
  input  logic                       pop,
  output logic [WIDTH-1:0]           head,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty,
  output logic                       ovf
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic [CW-1:0]    cnt;
  logic             ovf_q;
  logic             do_pop;
  logic             do_push;

  assign do_pop  = pop && (cnt != '0);
  // A full lane still accepts a push when the head leaves at the same edge.
  assign do_push = push && ((cnt != CW'(DEPTH)) || do_pop);

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
      ovf_q  <= 1'b0;
    end else begin
      // DEPTH is a power of two, so pointers wrap by natural overflow.
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
      if (push && !do_push) ovf_q <= 1'b1;
    end
  end

  // Storage carries no reset; the count alone defines which entries are live.
  always_ff @(posedge clk) begin
    if (!reset && do_push) mem[wr_ptr] <= din;
  end

  assign head  = mem[rd_ptr];
  assign count = cnt;
  assign full  = (cnt == CW'(DEPTH));
  assign empty = (cnt == '0);
  assign ovf   = ovf_q;
endmodule

// File: rtl/mux2a1_ochobits_cond.sv
// mux2a1_ochobits_cond: recombines two 8-bit lanes into one stream on clk_4f,
// taking words strictly lane 0, lane 1, lane 0, ... so the original byte order
// is restored. Each lane is buffered by a lane_fifo.
// Ports:
//   clk_4f  sole clock, rising edge.
//   reset   synchronous, active-high.
//   bus     slave side of mux2a1_ochobits_cond_if: lane inputs (validN,
//           data_inN), registered output pair (valid_out, data_out), the
//           lane pointer sel, and per-lane full/ovf flags.
module mux2a1_ochobits_cond
  import mux_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic                    clk_4f,
  input  logic                    reset,
  mux2a1_ochobits_cond_if.slave   bus
);
  logic [WIDTH-1:0]          head0, head1;
  logic [$clog2(DEPTH):0]    count0, count1;
  logic                      full0, full1;
  logic                      empty0, empty1;
  logic                      ovf0, ovf1;
  logic                      pop0, pop1;

  logic                      sel_q;
  logic                      valid_q;
  logic [WIDTH-1:0]          data_q;

  // Only the lane sel points at may be popped; an empty selected lane stalls
  // the output even when the other lane has data.
  assign pop0 = (sel_q == LANE0) && !empty0;
  assign pop1 = (sel_q == LANE1) && !empty1;

  lane_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_lane0 (
    .clk   (clk_4f),
    .reset (reset),
    .push  (bus.valid0),
    .din   (bus.data_in0),
    .pop   (pop0),
    .head  (head0),
    .count (count0),
    .full  (full0),
    .empty (empty0),
    .ovf   (ovf0)
  );

  lane_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_lane1 (
    .clk   (clk_4f),
    .reset (reset),
    .push  (bus.valid1),
    .din   (bus.data_in1),
    .pop   (pop1),
    .head  (head1),
    .count (count1),
    .full  (full1),
    .empty (empty1),
    .ovf   (ovf1)
  );

  always_ff @(posedge clk_4f) begin
    if (reset) begin
      sel_q   <= LANE0;
      valid_q <= 1'b0;
      data_q  <= '0;
    end else if (pop0 || pop1) begin
      data_q  <= (sel_q == LANE1) ? head1 : head0;
      valid_q <= 1'b1;
      sel_q   <= ~sel_q;
    end else begin
      valid_q <= 1'b0;
    end
  end

  assign bus.valid_out = valid_q;
  assign bus.data_out  = data_q;
  assign bus.sel       = sel_q;
  assign bus.full0     = full0;
  assign bus.full1     = full1;
  assign bus.ovf0      = ovf0;
  assign bus.ovf1      = ovf1;
endmodule

// File: doc/mux2a1_ochobits_cond.md
# mux2a1_ochobits_cond

Two-lane to one-lane 8-bit interleaver: the transmit-side counterpart of the 1-to-2 byte demux, it recombines lane 0 and lane 1 words into a single stream on `clk_4f`. Each lane has a small elastic FIFO, and output alternates strictly lane 0, lane 1, lane 0, and so on, restoring the original byte order. It sits between the two per-lane paths and the single 8-bit serialiser input.

## Interface
Parameters:
- `WIDTH`, default 8: data word width.
- `DEPTH`, default 2: entries per lane FIFO; power of two, at least 2.

Ports:
- `clk_4f`  in  1  sole clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `valid0`  in  1  lane 0 word present this cycle.
- `data_in0`  in  WIDTH  lane 0 word.
- `valid1`  in  1  lane 1 word present this cycle.
- `data_in1`  in  WIDTH  lane 1 word.
- `valid_out`  out  1  `data_out` carries a new word this cycle.
- `data_out`  out  WIDTH  interleaved output word (registered).
- `sel`  out  1  lane the next output word is taken from.
- `full0`, `full1`  out  1 each  lane FIFO holds `DEPTH` words.
- `ovf0`, `ovf1`  out  1 each  sticky overflow flag per lane.

## Operation
- Reset, sampled high at an edge:
  - both FIFOs empty;
  - `sel`=0;
  - `valid_out`=0, `data_out`=0;
  - `ovf0` and `ovf1` cleared.
  - Reset wins over every other event in that cycle; words presented during reset are discarded.
- Push: `validN`=1 at an edge writes `data_inN` into lane N's FIFO.
- Pop, registered output:
  - At each edge, if FIFO[`sel`] is non-empty: `data_out` is loaded with its head, `valid_out` goes to 1, the head is popped and `sel` toggles.
  - Otherwise `valid_out` goes to 0, while `data_out` and `sel` hold.
- Strict alternation: if the lane `sel` points to is empty, output stalls even when the other lane holds data. There is no skipping and no reordering.
- Full lane, push and pop at the same edge: both happen, count is unchanged and no overflow is flagged.
- Full lane, push without pop: the word is dropped, FIFO contents are unchanged, and `ovfN` is set and holds until reset.
- Push into an empty lane is not visible to the pop at the same edge; there is no bypass.
- `fullN` is combinational from the lane count (count == `DEPTH`).
- Both lanes push in the same cycle: both are accepted independently.
- Pointers wrap modulo `DEPTH`. Count width is $clog2(`DEPTH`)+1.

## Timing
- Latency: word sampled on lane N at edge t, with `sel`=N and the FIFO empty, appears on `data_out` with `valid_out`=1 after edge t+1.
- Throughput: one word per cycle when both lanes are fed at half rate in alternating phase, or both fed every other cycle.
- `sel`, `fullN`, `ovfN` and the output pair all change only at rising edges, apart from the combinational `fullN` decode of registered count.
- Reset mid-stream: outputs go to their reset values after the reset edge, and the first post-reset word is taken from lane 0.

## Structure
- Shared package `mux_pkg`: `WIDTH_DEF`=8, `DEPTH_DEF`=2, and lane index constants `LANE0`=1'b0, `LANE1`=1'b1.
- One natural sub-module, `lane_fifo`: synchronous FIFO with push, pop, head, count, full, empty and sticky ovf. It is instantiated twice.
- The top level holds only the `sel` flip-flop, the output register and the pop-select logic.

## Test plan
- Reset: hold `reset`=1 for 2 cycles with both valids high → `valid_out`=0, `data_out`=0x00, `sel`=0, `ovf0`=`ovf1`=0, and nothing emitted after release.
- Ordered recombination: lane 0 pushes 0x11, 0x33 and lane 1 pushes 0x22, 0x44, both valid every other cycle → output sequence 0x11, 0x22, 0x33, 0x44, with first `valid_out` one cycle after the first push.
- Alternation stall: push 0xA0, 0xA1, 0xA2 on lane 0 only → emits 0xA0, then `valid_out`=0 with `sel`=1 and `data_out` held at 0xA0. A later lane 1 push of 0xB0 → emits 0xB0 then 0xA1.
- Overflow: stall lane 0 by keeping lane 1 empty after one pop and push 4 words into lane 0 with `DEPTH`=2 → `full0`=1, `ovf0`=1 and stays 1, and only the first words that fit are later emitted in order.
- Push and pop while full: lane 0 full, `sel`=0, push 0x5A at the same edge → pop occurs, 0x5A is accepted, `ovf0` stays 0.
- Reset mid-operation: both FIFOs partially full and `sel`=1, assert reset for 1 cycle → FIFOs empty, `sel`=0, and the next lane 0 push is the next output.
